// File: rtl/sar_search_ctrl.sv
// Binary-search controller driving the A side of an external magnitude comparator.
// Each start runs one search; result, flags, step count and last guess hold until the next start.
module sar_search_ctrl #(
  parameter int N  = 8,
  parameter int SW = $clog2(N + 2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          G,
  input  logic          E,
  input  logic          L,
  output logic [N-1:0]  guess,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic          err,
  output logic [N-1:0]  result,
  output logic [SW-1:0] steps
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_CMP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [N:0]    HI_INIT  = {1'b0, {N{1'b1}}};
  localparam logic [N:0]    ONE_W    = {{N{1'b0}}, 1'b1};
  localparam logic [SW-1:0] STEP_ONE = {{(SW-1){1'b0}}, 1'b1};

  // True when exactly one of the three comparator flags is asserted.
  function automatic logic flags_onehot(input logic g, input logic e, input logic l);
    return (g ^ e ^ l) & ~(g & e & l);
  endfunction

  state_t        state_q;
  logic [N:0]    lo_q;
  logic [N:0]    hi_q;
  logic [N-1:0]  guess_q;
  logic [N-1:0]  result_q;
  logic [SW-1:0] steps_q;
  logic          busy_q;
  logic          done_q;
  logic          found_q;
  logic          err_q;

  logic [N-1:0]  mid_d;
  logic [N:0]    guess_ext_d;
  logic [N:0]    hi_dec_d;
  logic [N:0]    lo_inc_d;
  logic          at_lo_d;
  logic          at_hi_d;
  logic          flags_ok_d;
  logic [SW-1:0] steps_inc_d;

  // Next-bound arithmetic; bounds are one bit wider so guess +/- 1 never wraps.
  always_comb begin
    guess_ext_d = {1'b0, guess_q};
    // In SETUP lo <= hi <= 2^N-1, so the low N bits carry the whole midpoint.
    mid_d       = lo_q[N-1:0] + ((hi_q[N-1:0] - lo_q[N-1:0]) >> 1);
    hi_dec_d    = guess_ext_d - ONE_W;
    lo_inc_d    = guess_ext_d + ONE_W;
    at_lo_d     = (guess_ext_d == lo_q);
    at_hi_d     = (guess_ext_d == hi_q);
    flags_ok_d  = flags_onehot(G, E, L);
    steps_inc_d = steps_q + STEP_ONE;
  end

  // Search FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lo_q     <= {(N+1){1'b0}};
      hi_q     <= {(N+1){1'b0}};
      guess_q  <= {N{1'b0}};
      result_q <= {N{1'b0}};
      steps_q  <= {SW{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q  <= S_SETUP;
            lo_q     <= {(N+1){1'b0}};
            hi_q     <= HI_INIT;
            steps_q  <= {SW{1'b0}};
            found_q  <= 1'b0;
            err_q    <= 1'b0;
            result_q <= {N{1'b0}};
            busy_q   <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_SETUP: begin
          guess_q <= mid_d;
          state_q <= S_CMP;
        end
        S_CMP: begin
          steps_q <= steps_inc_d;
          if (!flags_ok_d) begin
            err_q   <= 1'b1;
            found_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (E) begin
            found_q  <= 1'b1;
            result_q <= guess_q;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else if (G) begin
            hi_q <= hi_dec_d;
            if (at_lo_d) begin
              found_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_SETUP;
            end
          end else begin
            lo_q <= lo_inc_d;
            if (at_hi_d) begin
              found_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_SETUP;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign guess  = guess_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign found  = found_q;
  assign err    = err_q;
  assign result = result_q;
  assign steps  = steps_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl: a plain binary-search model builds a per-cycle expected
// timeline for each search and one negedge process compares every output against it.
module tb_sar_search_ctrl;
  localparam int N  = 8;
  localparam int SW = $clog2(N + 2);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          G, E, L;
  logic [N-1:0]  guess, result;
  logic          busy, done, found, err;
  logic [SW-1:0] steps;

  int total = 0;
  int bad   = 0;
  int cmp_mode   = 0;   // 0 real comparator, 1 no flag, 2 G and L, 3 always L
  int cmp_target = 0;
  int pg = 0;           // guess the DUT should still hold from the previous search

  typedef struct {
    int busy; int done; int guess; int found; int err; int result; int steps;
  } exp_t;
  exp_t exp_q[$];

  int m_g[$];
  int m_found, m_err, m_result;

  always #5 clk = ~clk;

  sar_search_ctrl #(.N(N), .SW(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .G(G), .E(E), .L(L),
    .guess(guess), .busy(busy), .done(done), .found(found), .err(err),
    .result(result), .steps(steps)
  );

  // Comparator seen by the DUT, combinational on its registered guess.
  always @* begin
    G = 1'b0; E = 1'b0; L = 1'b0;
    case (cmp_mode)
      0: begin
        G = (int'(guess) > cmp_target);
        E = (int'(guess) == cmp_target);
        L = (int'(guess) < cmp_target);
      end
      2: begin G = 1'b1; L = 1'b1; end
      3: L = 1'b1;
      default: ;
    endcase
  end

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, want, $time);
    end
  endtask

  // Single compare process: one expected entry per cycle while a search is tracked.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("busy",   int'(busy),   e.busy);
      chk("done",   int'(done),   e.done);
      chk("guess",  int'(guess),  e.guess);
      chk("found",  int'(found),  e.found);
      chk("err",    int'(err),    e.err);
      chk("result", int'(result), e.result);
      chk("steps",  int'(steps),  e.steps);
    end
  end

  // Plain integer binary search producing the guess sequence and final verdict.
  task automatic model(input int mode, input int target);
    int lo, hi, g;
    m_g.delete();
    m_found = 0; m_err = 0; m_result = 0;
    lo = 0; hi = (1 << N) - 1;
    if (mode == 1 || mode == 2) begin
      m_g.push_back((lo + hi) / 2);
      m_err = 1;
    end else begin
      while (lo <= hi) begin
        g = (lo + hi) / 2;
        m_g.push_back(g);
        if (mode == 0 && g == target) begin
          m_found = 1; m_result = g;
          break;
        end else if (mode == 0 && g > target) begin
          hi = g - 1;
        end else begin
          lo = g + 1;
        end
      end
    end
  endtask

  // One search: start seen at edge 0, k-th compare in cycle 2k, done in cycle 2K+1.
  task automatic run(input int mode, input int target, input int pulse_at, input int rst_at);
    int k, len;
    exp_t e;
    cmp_mode = mode; cmp_target = target;
    model(mode, target);
    k = m_g.size();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    len = (rst_at > 0) ? rst_at + 2 : 2 * k + 2;
    for (int c = 1; c <= len; c++) begin
      if (rst_at > 0 && c > rst_at)      e = '{0, 0, 0, 0, 0, 0, 0};
      else if (c == 1)                   e = '{1, 0, pg, 0, 0, 0, 0};
      else if (c <= 2 * k && c % 2 == 0) e = '{1, 0, m_g[c/2 - 1], 0, 0, 0, c/2 - 1};
      else if (c <= 2 * k)               e = '{1, 0, m_g[(c-1)/2 - 1], 0, 0, 0, (c-1)/2};
      else e = '{0, (c == 2*k + 1) ? 1 : 0, m_g[k-1], m_found, m_err, m_result, k};
      exp_q.push_back(e);
    end
    pg = (rst_at > 0) ? 0 : m_g[k-1];
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      start = (c == pulse_at);
      rst   = (c == rst_at);
    end
    start = 1'b0; rst = 1'b0;
  endtask

  initial begin
    int pin5a[8];
    pin5a = '{127, 63, 95, 79, 87, 91, 89, 90};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);   chk("rst_done", int'(done), 0);
    chk("rst_guess", int'(guess), 0); chk("rst_found", int'(found), 0);
    chk("rst_err", int'(err), 0);     chk("rst_result", int'(result), 0);
    chk("rst_steps", int'(steps), 0);
    rst = 1'b0;

    model(0, 8'h5A);
    chk("pin5a_len", m_g.size(), 8);
    for (int i = 0; i < 8; i++) chk("pin5a_guess", m_g[i], pin5a[i]);
    chk("pin5a_done_cycle", 2 * m_g.size() + 1, 17);
    run(0, 8'h5A, 0, 0);
    chk("t5a_result", int'(result), 90); chk("t5a_steps", int'(steps), 8);
    chk("t5a_found", int'(found), 1);    chk("t5a_err", int'(err), 0);

    model(0, 255);
    chk("pin255_len", m_g.size(), 9);
    chk("pin255_last", m_g[8], 255);
    run(0, 255, 0, 0);
    chk("t255_result", int'(result), 255); chk("t255_steps", int'(steps), 9);

    model(0, 0);
    chk("pin0_len", m_g.size(), 8);
    chk("pin0_last", m_g[7], 0);
    run(0, 0, 0, 0);
    chk("t0_found", int'(found), 1); chk("t0_result", int'(result), 0);

    run(1, 0, 0, 0);
    chk("none_err", int'(err), 1); chk("none_steps", int'(steps), 1);
    chk("none_found", int'(found), 0);
    run(2, 0, 0, 0);
    chk("gl_err", int'(err), 1); chk("gl_guess", int'(guess), 127);

    run(3, 0, 0, 0);
    chk("oor_found", int'(found), 0); chk("oor_err", int'(err), 0);
    chk("oor_steps", int'(steps), 9); chk("oor_guess", int'(guess), 255);

    run(0, 8'h5A, 0, 9);
    chk("abort_guess", int'(guess), 0); chk("abort_done", int'(done), 0);

    run(0, 200, 4, 0);
    chk("ign_result", int'(result), 200); chk("ign_busy", int'(busy), 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
Sequential binary-search controller that drives the A side of an external N-bit magnitude comparator and consumes its G/E/L flags. It locates an unknown value presented on the comparator's B input. It is the driving/consuming end of the comparator's A/B -> G/E/L interface, used for threshold finding and value recovery. One search runs per start pulse, and the result is held until the next search.

Parameters:
N, 8, data width of guess/result; search range 0 .. 2^N-1
SW, $clog2(N+2), width of step counter; must hold N+1

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  begin search; sampled only in IDLE
G  input  1  comparator flag, guess > target
E  input  1  comparator flag, guess == target
L  input  1  comparator flag, guess < target
guess  output  N  registered value driven to comparator A
busy  output  1  high from the cycle after start until DONE, inclusive of all SETUP/CMP cycles
done  output  1  one-cycle pulse at end of search
found  output  1  held: last search ended on E
err  output  1  held: last search ended on an illegal flag pattern
result  output  N  held: guess at which E was seen; 0 if not found
steps  output  SW  held: number of CMP cycles executed in last search

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE.
  - guess, result, steps, lo, hi = 0; busy, done, found, err = 0.
  - Reset overrides everything, including mid-search; no done pulse is produced for an aborted search.
- Internal bounds lo, hi are N+1 bits wide so that guess-1 and guess+1 never wrap.
- States: IDLE, SETUP, CMP, DONE.
- IDLE:
  - done=0.
  - start=1 -> SETUP; lo=0, hi=2^N-1, steps=0, found=0, err=0, result=0.
- SETUP:
  - guess <= lo + ((hi-lo)>>1) (floor midpoint) -> CMP.
- CMP (flags sampled this cycle; the comparator is combinational on the registered guess):
  - steps <= steps+1.
  - Legal flags are exactly one of G/E/L high. Any other pattern -> err=1, found=0 -> DONE.
  - E: found=1, result=guess -> DONE.
  - G: hi <= guess-1. If guess==lo (new hi < lo) -> found=0 -> DONE; else -> SETUP.
  - L: lo <= guess+1. If guess==hi (new lo > hi) -> found=0 -> DONE; else -> SETUP.
- DONE:
  - done=1 for exactly this cycle; busy=0 -> IDLE.
  - guess, result, found, err and steps hold until the next accepted start.
- busy=1 in SETUP and CMP only.
- Timing: start seen at cycle 0 -> first SETUP at cycle 1, k-th CMP at cycle 2k, done at cycle 2k+1.
- Compare count: at most N+1 for a consistent comparator (9 for N=8).
- start high outside IDLE is ignored. start held high continuously restarts a new search on each IDLE visit (back-to-back: DONE -> IDLE -> SETUP).

Test Plan:
- N=8, target B=0x5A, model comparator, start at cycle 0 -> guesses 127,63,95,79,87,91,89,90; done at cycle 17; found=1, result=0x5A, steps=8, err=0.
- Target B=255 -> guesses 127,191,223,239,247,251,253,254,255; steps=9 (worst case), done at cycle 19, result=255.
- Target B=0 -> guesses 127,63,31,15,7,3,1,0; steps=8, found=1, result=0; no underflow of hi.
- Bench forces G=0,E=0,L=0 on first CMP -> done at cycle 3, err=1, found=0, steps=1. Then force G=L=1 on a later run -> same err behaviour.
- Bench forces L=1 on every compare (target out of range) -> search ends at lo > hi after guess=255; found=0, err=0, steps=9.
- rst=1 in the cycle after the 4th CMP of a search -> next cycle all outputs 0, state IDLE, no done pulse. start pulsed during busy in a separate run -> ignored, result unchanged.
